pdm_cic_decimator: RTL

//  Upstream stage of the MEMS microphone capture path. Samples the 1-bit PDM stream from the microphone and

---
 rtl/pdm_cic_decimator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
// Captures a MEMS microphone PDM bit stream, runs it through a CIC_ORDER-stage CIC
// decimator (R = 2**DEC_LOG2) and hands out signed OUT_WIDTH-bit PCM samples on a
// valid/ready interface. Samples that arrive while the previous one is still
// unconsumed are dropped and counted.
module pdm_cic_decimator #(
  parameter int CIC_ORDER = 4,
  parameter int DEC_LOG2  = 6,
  parameter int OUT_WIDTH = 8,
  parameter int ACC_WIDTH = 26
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        pdm_clk,
  input  logic                        pdm,
  output logic signed [OUT_WIDTH-1:0] sample_data,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic                        overrun,
  output logic [15:0]                 overrun_count
);

  localparam int SHIFT = CIC_ORDER * DEC_LOG2 + 1 - OUT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [DEC_LOG2-1:0] DEC_LAST = {DEC_LOG2{1'b1}};

  // Both reset and a disabled block wipe the datapath; only reset clears overrun stats.
  logic clear;
  assign clear = !reset || !enable;

  logic pdm_clk_meta, pdm_clk_sync, pdm_clk_last;
  logic pdm_meta, pdm_sync;
  logic bit_stb, dec_stb;
  logic [DEC_LOG2-1:0] dec_count;
  logic signed [ACC_WIDTH-1:0] x_in;
  logic signed [ACC_WIDTH-1:0] integ [CIC_ORDER];
  logic signed [ACC_WIDTH-1:0] comb_in;
  logic                        comb_in_valid;
  logic signed [ACC_WIDTH-1:0] comb_delay [CIC_ORDER];
  logic signed [ACC_WIDTH-1:0] comb_stage [CIC_ORDER+1];
  logic signed [ACC_WIDTH-1:0] comb_out;
  logic                        comb_valid;
  logic signed [ACC_WIDTH-1:0] scaled;
  logic signed [OUT_WIDTH-1:0] sat_sample;

  assign bit_stb = pdm_clk_sync && !pdm_clk_last;
  assign dec_stb = bit_stb && (dec_count == DEC_LAST);
  assign x_in    = pdm_sync ? ACC_WIDTH'(1) : {ACC_WIDTH{1'b1}};

  // Two-flop synchronizers for the microphone clock and data, plus edge history.
  always_ff @(posedge clock) begin
    if (clear) begin
      pdm_clk_meta <= 1'b0;
      pdm_clk_sync <= 1'b0;
      pdm_clk_last <= 1'b0;
      pdm_meta     <= 1'b0;
      pdm_sync     <= 1'b0;
    end else begin
      pdm_clk_meta <= pdm_clk;
      pdm_clk_sync <= pdm_clk_meta;
      pdm_clk_last <= pdm_clk_sync;
      pdm_meta     <= pdm;
      pdm_sync     <= pdm_meta;
    end
  end

  // Integrator chain and decimation counter; integrators wrap modulo 2**ACC_WIDTH by design.
  always_ff @(posedge clock) begin
    if (clear) begin
      dec_count <= '0;
      for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
    end else if (bit_stb) begin
      dec_count <= dec_count + DEC_LOG2'(1);
      integ[0]  <= integ[0] + x_in;
      for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Latch the last integrator (pre-update value) once per decimation period.
  always_ff @(posedge clock) begin
    if (clear) begin
      comb_in       <= '0;
      comb_in_valid <= 1'b0;
    end else begin
      comb_in_valid <= dec_stb;
      if (dec_stb) comb_in <= integ[CIC_ORDER-1];
    end
  end

  // Cascaded comb differences, each against its own one-sample delay.
  always_comb begin
    comb_stage[0] = comb_in;
    for (int k = 0; k < CIC_ORDER; k++) comb_stage[k+1] = comb_stage[k] - comb_delay[k];
  end

  // Register the comb result and advance the delays only on decimated samples.
  always_ff @(posedge clock) begin
    if (clear) begin
      comb_out   <= '0;
      comb_valid <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) comb_delay[k] <= '0;
    end else begin
      comb_valid <= comb_in_valid;
      if (comb_in_valid) begin
        comb_out <= comb_stage[CIC_ORDER];
        for (int k = 0; k < CIC_ORDER; k++) comb_delay[k] <= comb_stage[k];
      end
    end
  end

  // Scale the full-gain comb output down to the PCM width and clamp it.
  always_comb begin
    scaled = comb_out >>> SHIFT;
    if (scaled > SAT_MAX)      sat_sample = OUT_MAX;
    else if (scaled < SAT_MIN) sat_sample = OUT_MIN;
    else                       sat_sample = scaled[OUT_WIDTH-1:0];
  end

  // Output register: load when free or being drained, otherwise hold the unconsumed sample.
  always_ff @(posedge clock) begin
    if (clear) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else if (comb_valid) begin
      if (!sample_valid || sample_ready) begin
        sample_data  <= sat_sample;
        sample_valid <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky overrun flag and saturating drop counter survive a disable but not a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else if (enable && comb_valid && sample_valid && !sample_ready) begin
      overrun <= 1'b1;
      if (overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
    end
  end

endmodule
